// File: rtl/wm8731_cfg_seq.sv
// WM8731 configuration sequencer: walks the fixed 11-entry codec register
// table and hands one control word at a time to the I2C write master. It
// retries NACKed writes, waits for the codec to settle after its soft
// reset, and reports completion or the failing table index.
module wm8731_cfg_seq #(
  parameter int MAX_RETRY = 3,
  parameter int RST_WAIT  = 1000,
  parameter int TIMEOUT   = 65535
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Go,
  input  logic        I2cBusy,
  input  logic        I2cDone,
  input  logic        I2cNack,
  output logic        I2cStart,
  output logic [15:0] I2cData,
  output logic        Busy,
  output logic        CfgDone,
  output logic        CfgErr,
  output logic [3:0]  ErrIdx
);

  localparam int TMAX = (TIMEOUT > RST_WAIT) ? TIMEOUT : RST_WAIT;
  localparam int TW   = $clog2(TMAX + 2);
  localparam int RW   = $clog2(MAX_RETRY + 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_REQ    = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_SETTLE = 3'd4;
  localparam logic [2:0] S_NEXT   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  localparam logic [3:0] LAST_IDX = 4'd10;

  // Control words {RegAddr[6:0], RegData[8:0]}; entry 0 is the soft reset.
  function automatic logic [15:0] cfg_word(input logic [3:0] i);
    case (i)
      4'd0:    cfg_word = 16'h1E00; // R15 reset
      4'd1:    cfg_word = 16'h0C00; // R6 power down control
      4'd2:    cfg_word = 16'h0017; // R0 left line in
      4'd3:    cfg_word = 16'h0217; // R1 right line in
      4'd4:    cfg_word = 16'h0479; // R2 left headphone
      4'd5:    cfg_word = 16'h0679; // R3 right headphone
      4'd6:    cfg_word = 16'h0812; // R4 analogue path
      4'd7:    cfg_word = 16'h0A00; // R5 digital path
      4'd8:    cfg_word = 16'h0E02; // R7 interface format
      4'd9:    cfg_word = 16'h1000; // R8 sampling control
      4'd10:   cfg_word = 16'h1201; // R9 active
      default: cfg_word = 16'h0000;
    endcase
  endfunction

  logic [2:0]    state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          start_q, start_d;
  logic [15:0]   data_q, data_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [3:0]    eidx_q, eidx_d;

  // Next-state logic for the sequencer; the single timer serves both the
  // transfer timeout in WAIT and the post-reset delay in SETTLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    timer_d = timer_q;
    start_d = 1'b0;
    data_d  = data_q;
    done_d  = done_q;
    err_d   = err_q;
    eidx_d  = eidx_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (Go) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          eidx_d  = '0;
          idx_d   = '0;
          retry_d = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        data_d  = cfg_word(idx_q);
        state_d = S_REQ;
      end
      S_REQ: begin
        // Hold here indefinitely while the master is busy; no timeout.
        if (!I2cBusy) begin
          start_d = 1'b1;
          timer_d = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A done on the same cycle as the timeout takes priority.
        if (I2cDone) begin
          if (!I2cNack) begin
            timer_d = '0;
            state_d = (idx_q == 4'd0) ? S_SETTLE : S_NEXT;
          end else if (int'(retry_q) < MAX_RETRY) begin
            retry_d = retry_q + 1'b1;
            state_d = S_REQ;
          end else begin
            err_d   = 1'b1;
            eidx_d  = idx_q;
            state_d = S_ERR;
          end
        end else if (int'(timer_q) + 1 >= TIMEOUT) begin
          err_d   = 1'b1;
          eidx_d  = idx_q;
          state_d = S_ERR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_SETTLE: begin
        if (int'(timer_q) + 1 >= RST_WAIT) state_d = S_NEXT;
        else                               timer_d = timer_q + 1'b1;
      end
      S_NEXT: begin
        retry_d = '0;
        if (idx_q == LAST_IDX) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset; reset abandons any transfer.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      retry_q <= '0;
      timer_q <= '0;
      start_q <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      eidx_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      timer_q <= timer_d;
      start_q <= start_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      eidx_q  <= eidx_d;
    end
  end

  assign I2cStart = start_q;
  assign I2cData  = data_q;
  assign Busy     = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  assign CfgDone  = done_q;
  assign CfgErr   = err_q;
  assign ErrIdx   = eidx_q;

endmodule

// File: tb/tb_wm8731_cfg_seq.sv
// Bench for wm8731_cfg_seq: an I2C master model answers each start after a
// (random) latency with a planned ACK/NACK, and the expected start list and
// outcome are derived from the register table and the NACK plan.
module tb_wm8731_cfg_seq;
  localparam int MAX_RETRY = 3;
  localparam int RST_WAIT  = 1000;
  localparam int TIMEOUT   = 100;

  logic        Clk = 1'b0;
  logic        Rst, Go, I2cBusy, I2cDone, I2cNack;
  logic        I2cStart, Busy, CfgDone, CfgErr;
  logic [15:0] I2cData;
  logic [3:0]  ErrIdx;

  wm8731_cfg_seq #(.MAX_RETRY(MAX_RETRY), .RST_WAIT(RST_WAIT), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Rst(Rst), .Go(Go), .I2cBusy(I2cBusy), .I2cDone(I2cDone),
    .I2cNack(I2cNack), .I2cStart(I2cStart), .I2cData(I2cData), .Busy(Busy),
    .CfgDone(CfgDone), .CfgErr(CfgErr), .ErrIdx(ErrIdx)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  initial forever @(posedge Clk) cyc++;

  logic [15:0] tbl [11] = '{16'h1E00, 16'h0C00, 16'h0017, 16'h0217, 16'h0479,
                            16'h0679, 16'h0812, 16'h0A00, 16'h0E02, 16'h1000, 16'h1201};

  // Master-model controls and logs.
  int          nack_cnt [11];
  int          att [11];
  bit          mute0;
  int          lat_min, lat_max;
  logic [15:0] st_word [$];
  int          st_cyc [$];
  int          dn_cyc [$];
  int          dbl_start, unstable;
  logic [15:0] cur_word;
  bit          pending, cur_nack;
  int          cnt;

  // Expected outcome.
  logic [15:0] exp_q [$];
  bit          exp_err;
  int          exp_idx;

  function automatic int idx_of(input logic [15:0] w);
    for (int i = 0; i < 11; i++) if (tbl[i] == w) return i;
    return -1;
  endfunction

  // I2C master model: done (with planned NACK) lat cycles after each start.
  initial begin
    int k;
    I2cDone = 1'b0; I2cNack = 1'b0; pending = 1'b0; cnt = 0;
    forever begin
      @(negedge Clk);
      I2cDone = 1'b0; I2cNack = 1'b0;
      if (pending) begin
        if (Busy && I2cData !== cur_word) unstable++;
        cnt--;
        if (cnt == 0) begin
          I2cDone = 1'b1; I2cNack = cur_nack; pending = 1'b0;
          dn_cyc.push_back(cyc + 1);
        end
      end
      if (I2cStart === 1'b1) begin
        if (pending) dbl_start++;
        st_word.push_back(I2cData); st_cyc.push_back(cyc);
        cur_word = I2cData;
        k = idx_of(I2cData);
        cur_nack = 1'b0;
        if (k >= 0) begin
          cur_nack = att[k] < nack_cnt[k];
          att[k]++;
        end
        pending = !(mute0 && k == 0);
        cnt = $urandom_range(lat_max, lat_min) - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    st_word.delete(); st_cyc.delete(); dn_cyc.delete();
    for (int i = 0; i < 11; i++) att[i] = 0;
    dbl_start = 0; unstable = 0;
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 11; i++) nack_cnt[i] = 0;
  endtask

  // Reference: each entry is attempted until ACKed or retries run out.
  task automatic build_exp();
    exp_q.delete(); exp_err = 1'b0; exp_idx = 0;
    for (int i = 0; i < 11; i++) begin
      if (nack_cnt[i] > MAX_RETRY) begin
        for (int a = 0; a <= MAX_RETRY; a++) exp_q.push_back(tbl[i]);
        exp_err = 1'b1; exp_idx = i;
        break;
      end
      for (int a = 0; a <= nack_cnt[i]; a++) exp_q.push_back(tbl[i]);
    end
  endtask

  task automatic pulse_go(output int gcyc);
    @(negedge Clk); Go = 1'b1; gcyc = cyc + 1;
    @(negedge Clk); Go = 1'b0;
  endtask

  task automatic wait_end(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge Clk);
      if (CfgDone || CfgErr) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_starts(input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge Clk);
      if (st_word.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic check_run(input string tag);
    int n;
    chk({tag, ".nstart"}, st_word.size(), exp_q.size());
    n = (st_word.size() < exp_q.size()) ? st_word.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s.word%0d", tag, i), st_word[i], exp_q[i]);
    chk({tag, ".done"}, CfgDone, !exp_err);
    chk({tag, ".err"}, CfgErr, exp_err);
    chk({tag, ".erridx"}, ErrIdx, exp_err ? exp_idx : 0);
    chk({tag, ".busy"}, Busy, 0);
    chk({tag, ".dblstart"}, dbl_start, 0);
    chk({tag, ".stable"}, unstable, 0);
  endtask

  bit ok;
  int g, n0, rel, ecyc, cnt3;

  initial begin
    Rst = 1'b1; Go = 1'b0; I2cBusy = 1'b0; mute0 = 1'b0;
    lat_min = 20; lat_max = 20;
    clear_plan(); clear_log();

    // Reset state
    repeat (2) @(negedge Clk);
    chk("rst.busy", Busy, 0); chk("rst.done", CfgDone, 0); chk("rst.err", CfgErr, 0);
    chk("rst.erridx", ErrIdx, 0); chk("rst.start", I2cStart, 0); chk("rst.data", I2cData, 0);
    Rst = 1'b0;

    // Nominal run with fixed 20-cycle done latency
    clear_log(); build_exp();
    pulse_go(g);
    wait_end(20000, ok);
    chk("nom.finish", ok, 1);
    check_run("nom");
    if (st_cyc.size() >= 1) chk("nom.latency", st_cyc[0] - g, 2);
    if (st_cyc.size() >= 2 && dn_cyc.size() >= 1)
      chk("nom.settle", (st_cyc[1] - dn_cyc[0]) >= RST_WAIT, 1);

    // NACK index 3 twice, then ACK; random latency
    clear_plan(); nack_cnt[3] = 2; lat_min = 2; lat_max = 60;
    clear_log(); build_exp();
    pulse_go(g);
    wait_end(20000, ok);
    chk("nack.finish", ok, 1);
    check_run("nack");
    cnt3 = 0;
    foreach (st_word[i]) if (st_word[i] == 16'h0217) cnt3++;
    chk("nack.r1starts", cnt3, 3);

    // Retry exhaustion at index 5
    clear_plan(); nack_cnt[5] = 9;
    clear_log(); build_exp();
    pulse_go(g);
    wait_end(20000, ok);
    chk("exh.finish", ok, 1);
    check_run("exh");
    n0 = st_word.size();
    repeat (200) @(negedge Clk);
    chk("exh.nomore", st_word.size(), n0);
    chk("exh.errheld", CfgErr, 1);

    // Timeout on index 0
    clear_plan(); mute0 = 1'b1; lat_min = 20; lat_max = 20;
    clear_log();
    pulse_go(g);
    ecyc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge Clk);
      if (CfgErr) begin ecyc = cyc; break; end
    end
    chk("tmo.seen", ecyc >= 0, 1);
    if (st_cyc.size() >= 1) chk("tmo.cycles", ecyc - st_cyc[0], TIMEOUT);
    chk("tmo.erridx", ErrIdx, 0);
    chk("tmo.done", CfgDone, 0);
    chk("tmo.nstart", st_word.size(), 1);
    mute0 = 1'b0;

    // Busy gating before index 2, Go pulsed mid-sequence
    clear_plan(); clear_log(); build_exp();
    pulse_go(g);
    wait_starts(2, 3000, ok);
    chk("bsy.reach", ok, 1);
    I2cBusy = 1'b1;
    n0 = st_word.size();
    repeat (25) @(negedge Clk);
    Go = 1'b1;
    @(negedge Clk);
    Go = 1'b0;
    repeat (24) @(negedge Clk);
    chk("bsy.nostart", st_word.size(), n0);
    I2cBusy = 1'b0; rel = cyc;
    wait_starts(n0 + 1, 20, ok);
    chk("bsy.resume", ok, 1);
    if (st_word.size() > n0) begin
      chk("bsy.word", st_word[n0], 16'h0017);
      chk("bsy.when", st_cyc[n0] - rel, 1);
    end
    wait_end(20000, ok);
    chk("bsy.finish", ok, 1);
    check_run("bsy");

    // Reset while waiting at index 4, then restart
    clear_plan(); clear_log();
    pulse_go(g);
    wait_starts(5, 3000, ok);
    chk("mrst.reach", ok, 1);
    repeat (5) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    chk("mrst.busy", Busy, 0); chk("mrst.done", CfgDone, 0); chk("mrst.err", CfgErr, 0);
    chk("mrst.erridx", ErrIdx, 0); chk("mrst.start", I2cStart, 0); chk("mrst.data", I2cData, 0);
    Rst = 1'b0;
    n0 = st_word.size();
    repeat (40) @(negedge Clk);
    chk("mrst.idle", Busy, 0);
    chk("mrst.quiet", st_word.size(), n0);
    clear_log(); build_exp();
    pulse_go(g);
    wait_end(20000, ok);
    chk("mrst.finish", ok, 1);
    check_run("mrst");

    // Randomized NACK plans and latencies
    lat_min = 2; lat_max = 60;
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < 11; i++)
        nack_cnt[i] = ($urandom_range(9, 0) < 7) ? 0 : int'($urandom_range(4, 1));
      clear_log(); build_exp();
      pulse_go(g);
      wait_end(20000, ok);
      chk($sformatf("rnd%0d.finish", it), ok, 1);
      check_run($sformatf("rnd%0d", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
